// File: rtl/multicycle_controller_if.sv
// Control bundle between the multicycle controller and the RV32I datapath.
// The controller is the master: it reads decode fields and status, and drives selects and strobes.
interface multicycle_controller_if #(
    parameter int IMMSRC_W = 3
);
    logic [6:0]          op;
    logic [2:0]          funct3;
    logic                Zero;
    logic                MemReady;
    logic                MemReq;
    logic                PCWrite;
    logic                AdrSrc;
    logic                MemWrite;
    logic                IRWrite;
    logic                RegWrite;
    logic [1:0]          ResultSrc;
    logic [1:0]          ALUSrcA;
    logic [1:0]          ALUSrcB;
    logic [1:0]          ALUOp;
    logic [IMMSRC_W-1:0] ImmSrc;
    logic                Illegal;
    logic                Halted;
    logic                InstrDone;

    modport master (
        input  op, funct3, Zero, MemReady,
        output MemReq, PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
               ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc, Illegal, Halted, InstrDone
    );

    modport slave (
        output op, funct3, Zero, MemReady,
        input  MemReq, PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
               ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc, Illegal, Halted, InstrDone
    );
endinterface

// File: rtl/multicycle_controller.sv
// Moore sequencing controller for the multicycle RV32I core, with memory wait states,
// illegal-opcode trap/halt and a retire pulse at the last state of every instruction.
module multicycle_controller #(
    parameter bit MEM_WAIT_EN  = 1'b1,
    parameter bit TRAP_ILLEGAL = 1'b1,
    parameter int IMMSRC_W     = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    multicycle_controller_if.master bus
);
    localparam logic [3:0] FETCH    = 4'd0;
    localparam logic [3:0] DECODE   = 4'd1;
    localparam logic [3:0] MEMADR   = 4'd2;
    localparam logic [3:0] MEMREAD  = 4'd3;
    localparam logic [3:0] MEMWB    = 4'd4;
    localparam logic [3:0] MEMWRITE = 4'd5;
    localparam logic [3:0] EXECR    = 4'd6;
    localparam logic [3:0] EXECI    = 4'd7;
    localparam logic [3:0] ALUWB    = 4'd8;
    localparam logic [3:0] BRANCH   = 4'd9;
    localparam logic [3:0] JAL      = 4'd10;
    localparam logic [3:0] JALR     = 4'd11;
    localparam logic [3:0] JALRWB   = 4'd12;
    localparam logic [3:0] UTYPE    = 4'd13;
    localparam logic [3:0] HALT     = 4'd14;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    logic [3:0] state, nextState;
    logic       stall;
    logic       pcUpdate, branch, taken;
    logic       memReq, adrSrc, memWrite, irWrite, regWrite, illegal, instrDone;
    logic [1:0] resultSrc, srcA, srcB, aluOp;
    logic [IMMSRC_W-1:0] immSrc;

    assign stall = MEM_WAIT_EN && !bus.MemReady;
    assign taken = bus.Zero ^ bus.funct3[0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= FETCH;
        else       state <= nextState;
    end

    always_comb begin
        nextState = state;
        pcUpdate  = 1'b0;
        branch    = 1'b0;
        memReq    = 1'b0;
        adrSrc    = 1'b0;
        memWrite  = 1'b0;
        irWrite   = 1'b0;
        regWrite  = 1'b0;
        illegal   = 1'b0;
        instrDone = 1'b0;
        resultSrc = 2'b00;
        srcA      = 2'b00;
        srcB      = 2'b00;
        aluOp     = 2'b00;
        case (state)
            FETCH: begin
                memReq    = 1'b1;
                srcB      = 2'b10;
                resultSrc = 2'b10;
                irWrite   = !stall;
                pcUpdate  = !stall;
                if (!stall) nextState = DECODE;
            end
            DECODE: begin
                srcA = 2'b01;
                srcB = 2'b01;
                case (bus.op)
                    OP_LOAD, OP_STORE: nextState = MEMADR;
                    OP_RTYPE:          nextState = EXECR;
                    OP_ITYPE:          nextState = EXECI;
                    OP_BRANCH:         nextState = BRANCH;
                    OP_JAL:            nextState = JAL;
                    OP_JALR:           nextState = JALR;
                    OP_LUI, OP_AUIPC:  nextState = UTYPE;
                    default: begin
                        illegal   = 1'b1;
                        nextState = TRAP_ILLEGAL ? HALT : FETCH;
                    end
                endcase
            end
            MEMADR: begin
                srcA      = 2'b10;
                srcB      = 2'b01;
                nextState = (bus.op == OP_LOAD) ? MEMREAD : MEMWRITE;
            end
            MEMREAD: begin
                memReq = 1'b1;
                adrSrc = 1'b1;
                if (!stall) nextState = MEMWB;
            end
            MEMWB: begin
                resultSrc = 2'b01;
                regWrite  = 1'b1;
                instrDone = 1'b1;
                nextState = FETCH;
            end
            // The write strobe and retire pulse wait for the accepting cycle so a stall never repeats them.
            MEMWRITE: begin
                memReq    = 1'b1;
                adrSrc    = 1'b1;
                memWrite  = !stall;
                instrDone = !stall;
                if (!stall) nextState = FETCH;
            end
            EXECR: begin
                srcA      = 2'b10;
                aluOp     = 2'b10;
                nextState = ALUWB;
            end
            EXECI: begin
                srcA      = 2'b10;
                srcB      = 2'b01;
                aluOp     = 2'b10;
                nextState = ALUWB;
            end
            ALUWB: begin
                regWrite  = 1'b1;
                instrDone = 1'b1;
                nextState = FETCH;
            end
            BRANCH: begin
                srcA      = 2'b10;
                aluOp     = 2'b01;
                branch    = 1'b1;
                instrDone = 1'b1;
                nextState = FETCH;
            end
            JAL: begin
                srcA      = 2'b01;
                srcB      = 2'b10;
                pcUpdate  = 1'b1;
                nextState = ALUWB;
            end
            JALR: begin
                srcA      = 2'b10;
                srcB      = 2'b01;
                resultSrc = 2'b10;
                pcUpdate  = 1'b1;
                nextState = JALRWB;
            end
            JALRWB: begin
                srcA      = 2'b01;
                srcB      = 2'b10;
                resultSrc = 2'b10;
                regWrite  = 1'b1;
                instrDone = 1'b1;
                nextState = FETCH;
            end
            UTYPE: begin
                srcA      = bus.op[5] ? 2'b11 : 2'b01;
                srcB      = 2'b01;
                nextState = ALUWB;
            end
            HALT:    nextState = HALT;
            default: nextState = FETCH;
        endcase
    end

    // U-type shares the S-type slot when only two ImmSrc bits are available.
    always_comb begin
        immSrc = '0;
        case (bus.op)
            OP_LOAD, OP_ITYPE, OP_JALR: immSrc = '0;
            OP_STORE:                   immSrc = IMMSRC_W'(1);
            OP_BRANCH:                  immSrc = IMMSRC_W'(2);
            OP_JAL:                     immSrc = IMMSRC_W'(3);
            OP_LUI, OP_AUIPC:           immSrc = (IMMSRC_W == 2) ? IMMSRC_W'(1) : IMMSRC_W'(4);
            default:                    immSrc = '0;
        endcase
    end

    assign bus.PCWrite   = !reset && (pcUpdate || (branch && taken));
    assign bus.MemReq    = !reset && memReq;
    assign bus.MemWrite  = !reset && memWrite;
    assign bus.IRWrite   = !reset && irWrite;
    assign bus.RegWrite  = !reset && regWrite;
    assign bus.Illegal   = !reset && illegal;
    assign bus.InstrDone = !reset && instrDone;
    assign bus.AdrSrc    = adrSrc;
    assign bus.ResultSrc = resultSrc;
    assign bus.ALUSrcA   = srcA;
    assign bus.ALUSrcB   = srcB;
    assign bus.ALUOp     = aluOp;
    assign bus.ImmSrc    = immSrc;
    assign bus.Halted    = (state == HALT);
endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized bench for two controller configurations run side by side against a
// per-instruction phase-table reference model.
module tb_multicycle_controller;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;

    int   stepA = 0, stepB = 0;
    bit   haltA = 0, haltB = 0;
    bit   obsDoneA, obsRegA, obsMemReqA;

    multicycle_controller_if #(.IMMSRC_W(3)) busA ();
    multicycle_controller_if #(.IMMSRC_W(2)) busB ();

    multicycle_controller #(.MEM_WAIT_EN(1'b1), .TRAP_ILLEGAL(1'b1), .IMMSRC_W(3)) dutA (
        .clk(clk), .reset(reset), .bus(busA.master));
    multicycle_controller #(.MEM_WAIT_EN(1'b0), .TRAP_ILLEGAL(1'b0), .IMMSRC_W(2)) dutB (
        .clk(clk), .reset(reset), .bus(busB.master));

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s at %0t: got %h, expected %h", tag, $time, observed, expected);
        end
    endtask

    // Instruction classes: 0 lw, 1 sw, 2 R, 3 I, 4 branch, 5 jal, 6 jalr, 7 lui, 8 auipc, 9 illegal
    function automatic int kindOf(input logic [6:0] o);
        case (o)
            7'b0000011: return 0;
            7'b0100011: return 1;
            7'b0110011: return 2;
            7'b0010011: return 3;
            7'b1100011: return 4;
            7'b1101111: return 5;
            7'b1100111: return 6;
            7'b0110111: return 7;
            7'b0010111: return 8;
            default:    return 9;
        endcase
    endfunction

    function automatic int lastStep(input int k);
        if (k == 4) return 2;
        if (k == 0) return 4;
        if (k == 9) return 1;
        return 3;
    endfunction

    function automatic logic [31:0] expImm(input logic [6:0] o, input int w);
        case (kindOf(o))
            1:       return 1;
            4:       return 2;
            5:       return 3;
            7, 8:    return (w == 3) ? 4 : 1;
            default: return 0;
        endcase
    endfunction

    // Expected control word for phase 'step' of the instruction class: FETCH=0, DECODE=1, ...
    function automatic logic [16:0] expCtl(input bit waitEn, input logic [6:0] o, input logic [2:0] f3,
                                           input int step, input bit halted, input bit rdy,
                                           input bit z, input bit rst);
        logic memReq = 0, pcW = 0, adr = 0, memW = 0, irW = 0, regW = 0, ill = 0, hlt = 0, done = 0;
        logic [1:0] rs = 0, a = 0, b = 0, alu = 0;
        bit stall = waitEn && !rdy;
        int k = kindOf(o);
        if (rst) begin
            b = 2; rs = 2;
        end else if (halted) begin
            hlt = 1;
        end else if (step == 0) begin
            memReq = 1; b = 2; rs = 2; irW = !stall; pcW = !stall;
        end else if (step == 1) begin
            a = 1; b = 1; ill = (k == 9);
        end else if (step == 2) begin
            case (k)
                0, 1: begin a = 2; b = 1; end
                2:    begin a = 2; b = 0; alu = 2; end
                3:    begin a = 2; b = 1; alu = 2; end
                4:    begin a = 2; alu = 1; pcW = z ^ f3[0]; done = 1; end
                5:    begin a = 1; b = 2; pcW = 1; end
                6:    begin a = 2; b = 1; rs = 2; pcW = 1; end
                7:    begin a = 3; b = 1; end
                default: begin a = 1; b = 1; end
            endcase
        end else if (step == 3) begin
            case (k)
                0:       begin memReq = 1; adr = 1; end
                1:       begin memReq = 1; adr = 1; memW = !stall; done = !stall; end
                6:       begin a = 1; b = 2; rs = 2; regW = 1; done = 1; end
                default: begin regW = 1; done = 1; end
            endcase
        end else begin
            rs = 1; regW = 1; done = 1;
        end
        return {memReq, pcW, adr, memW, irW, regW, rs, a, b, alu, ill, hlt, done};
    endfunction

    task automatic advance(input bit waitEn, input bit trap, input logic [6:0] o, input bit rdy,
                           input bit rst, inout int step, inout bit halted, output bit fresh);
        int k = kindOf(o);
        bit stall = waitEn && !rdy;
        fresh = 0;
        if (rst) begin
            step = 0; halted = 0; fresh = 1;
        end else if (!halted) begin
            if ((step == 0 || (step == 3 && k <= 1)) && stall) begin
                step = step;
            end else if (step == 1 && k == 9) begin
                if (trap) halted = 1;
                else begin step = 0; fresh = 1; end
            end else if (step == lastStep(k)) begin
                step = 0; fresh = 1;
            end else begin
                step++;
            end
        end
    endtask

    function automatic logic [6:0] randomOp();
        logic [6:0] opList [9] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011,
                                   7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};
        if ($urandom_range(0, 19) == 0) return 7'($urandom_range(0, 127));
        return opList[$urandom_range(0, 8)];
    endfunction

    // One clock: check outputs just after the falling edge, step the models at the rising edge.
    task automatic applyStimulus();
        logic [6:0] sOpA, sOpB;
        bit sRdyA, sRdyB, sRst, nA, nB;
        #1;
        checkOutput("ctlA", 32'({busA.MemReq, busA.PCWrite, busA.AdrSrc, busA.MemWrite, busA.IRWrite,
                                 busA.RegWrite, busA.ResultSrc, busA.ALUSrcA, busA.ALUSrcB, busA.ALUOp,
                                 busA.Illegal, busA.Halted, busA.InstrDone}),
                    32'(expCtl(1'b1, busA.op, busA.funct3, stepA, haltA, busA.MemReady, busA.Zero, reset)));
        checkOutput("ctlB", 32'({busB.MemReq, busB.PCWrite, busB.AdrSrc, busB.MemWrite, busB.IRWrite,
                                 busB.RegWrite, busB.ResultSrc, busB.ALUSrcA, busB.ALUSrcB, busB.ALUOp,
                                 busB.Illegal, busB.Halted, busB.InstrDone}),
                    32'(expCtl(1'b0, busB.op, busB.funct3, stepB, haltB, busB.MemReady, busB.Zero, reset)));
        checkOutput("immA", 32'(busA.ImmSrc), expImm(busA.op, 3));
        checkOutput("immB", 32'(busB.ImmSrc), expImm(busB.op, 2));
        obsDoneA   = busA.InstrDone;
        obsRegA    = busA.RegWrite;
        obsMemReqA = busA.MemReq;
        sOpA = busA.op; sOpB = busB.op;
        sRdyA = busA.MemReady; sRdyB = busB.MemReady; sRst = reset;
        @(posedge clk);
        advance(1'b1, 1'b1, sOpA, sRdyA, sRst, stepA, haltA, nA);
        advance(1'b0, 1'b0, sOpB, sRdyB, sRst, stepB, haltB, nB);
        @(negedge clk);
        if (nA) begin busA.op = randomOp(); busA.funct3 = 3'($urandom_range(0, 7)); end
        if (nB) begin busB.op = randomOp(); busB.funct3 = 3'($urandom_range(0, 7)); end
    endtask

    initial begin
        logic pat [10] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        int doneCycle, regCount;

        busA.op = 7'b0110011; busA.funct3 = 0; busA.Zero = 0; busA.MemReady = 1;
        busB.op = 7'b0110011; busB.funct3 = 0; busB.Zero = 0; busB.MemReady = 1;
        @(negedge clk);
        applyStimulus();

        // lw with two FETCH and three MEMREAD wait cycles retires on cycle 10 with one write.
        reset = 0;
        busA.op = 7'b0000011;
        doneCycle = 0; regCount = 0;
        for (int c = 1; c <= 10; c++) begin
            busA.MemReady = pat[c-1];
            applyStimulus();
            if (obsDoneA && doneCycle == 0) doneCycle = c;
            regCount += int'(obsRegA);
        end
        checkOutput("lwDoneCycle", doneCycle, 10);
        checkOutput("lwRegWrites", regCount, 1);

        // Reset during a stalled MEMREAD must abort without any register write.
        reset = 1; busA.MemReady = 1; applyStimulus();
        reset = 0; busA.op = 7'b0000011; regCount = 0;
        for (int c = 1; c <= 4; c++) begin
            busA.MemReady = (c != 4);
            applyStimulus();
            regCount += int'(obsRegA);
        end
        busA.MemReady = 0; reset = 1;
        applyStimulus();
        regCount += int'(obsRegA);
        checkOutput("rstMemReq", 32'(obsMemReqA), 0);
        reset = 0;
        applyStimulus();
        regCount += int'(obsRegA);
        checkOutput("rstNoRegWrite", regCount, 0);

        // Illegal opcode: A halts for good, B resumes fetching.
        reset = 1; applyStimulus();
        reset = 0; busA.op = 7'h7f; busB.op = 7'h7f; busA.MemReady = 1; busB.MemReady = 1;
        for (int c = 0; c < 8; c++) applyStimulus();
        checkOutput("haltStays", 32'(busA.Halted), 1);

        reset = 1; applyStimulus();
        reset = 0;
        for (int c = 0; c < 4000; c++) begin
            reset = ($urandom_range(0, 99) == 0);
            busA.MemReady = ($urandom_range(0, 3) != 0);
            busB.MemReady = $urandom_range(0, 1);
            busA.Zero = $urandom_range(0, 1);
            busB.Zero = $urandom_range(0, 1);
            applyStimulus();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
